uart_echo_responder: RTL

Remote end of the null-modem link. Receives 16x-oversampled serial frames (1 start, 8 data LSB first, 1 stop) from the controller/transmitter side, checks framing, buffers good bytes in a small FIFO, and retransmits them unchanged on its own serial output. It acts as the responder for the existing controller/UART initiator, so a bench can check the round-trip byte stream end to end.

---
 rtl/uart_echo_responder_if.sv | 34 +++
 rtl/uart_echo_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo_responder_if
//  Purpose  : Serial line, echo enable and receive status bundle for the
//             UART echo responder.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_echo_responder_if #(
  parameter int DEPTH = 4
);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic               serial_in;
  logic               echo_en;
  logic               serial_out;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               frame_err;
  logic               overrun;
  logic [c_cnt_w-1:0] fifo_count;

  // Driving side (bench / link partner)
  modport master (
    output serial_in, echo_en,
    input  serial_out, rx_data, rx_valid, frame_err, overrun, fifo_count
  );

  // Responder side
  modport slave (
    input  serial_in, echo_en,
    output serial_out, rx_data, rx_valid, frame_err, overrun, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/uart_echo_responder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo_responder
//  Purpose  : 16x-oversampled UART receiver feeding a small FIFO whose good
//             bytes are retransmitted unchanged on the serial output.
//  Revision : 1.0  initial release
// ============================================================================
module uart_echo_responder #(
  parameter int DEPTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  uart_echo_responder_if.slave bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  rx_state_t          r_rx_state;
  logic               r_rx_in;
  logic [3:0]         r_rx_cnt;
  logic [2:0]         r_rx_idx;
  logic [7:0]         r_rx_shift;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic               r_frame_err;
  logic               r_overrun;

  logic [7:0]         r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  tx_state_t          r_tx_state;
  logic [9:0]         r_tx_shift;
  logic [3:0]         r_tx_cnt;
  logic [3:0]         r_bit_no;
  logic               r_serial_out;

  logic               w_sample;
  logic               w_rx_good;
  logic               w_full;
  logic               w_pop;
  logic               w_push;

  assign w_sample  = (r_rx_cnt == 4'd7);
  assign w_rx_good = (r_rx_state == RX_STOP) && w_sample && r_rx_in;
  assign w_full    = (r_count == c_depth);
  // The transmitter takes the head entry in the same cycle it leaves IDLE
  assign w_pop     = (r_tx_state == TX_IDLE) && bus.echo_en && (r_count != '0);
  // A full FIFO still accepts when the head is leaving in the same cycle
  assign w_push    = w_rx_good && (!w_full || w_pop);

  // Receive path: input register plus start/data/stop/break framing FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_in     <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= 4'd0;
      r_rx_idx    <= 3'd0;
      r_rx_shift  <= 8'd0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_in     <= bus.serial_in;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_in) begin
            // The detecting cycle already counts as the first start-bit cycle,
            // so the phase-7 sample lands on the start bit's midpoint.
            r_rx_state <= RX_START;
            r_rx_cnt   <= 4'd1;
          end
        end
        RX_START: begin
          r_rx_cnt <= r_rx_cnt + 4'd1;
          if (w_sample) begin
            if (r_rx_in) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_DATA;
              r_rx_idx   <= 3'd0;
            end
          end
        end
        RX_DATA: begin
          r_rx_cnt <= r_rx_cnt + 4'd1;
          if (w_sample) begin
            r_rx_shift[r_rx_idx] <= r_rx_in;
            if (r_rx_idx == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 3'd1;
            end
          end
        end
        RX_STOP: begin
          r_rx_cnt <= r_rx_cnt + 4'd1;
          if (w_sample) begin
            if (r_rx_in) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_rx_state  <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          if (r_rx_in) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_w'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cnt_w'(1);
      end
      if (w_rx_good && !w_push) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_rx_shift;
    end
  end

  // Transmit FSM: load a 10-bit frame from the FIFO head and shift it out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state   <= TX_IDLE;
      r_tx_shift   <= 10'h3FF;
      r_tx_cnt     <= 4'd0;
      r_bit_no     <= 4'd0;
      r_serial_out <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_serial_out <= 1'b1;
          if (w_pop) begin
            r_tx_shift   <= {1'b1, r_mem[r_rd_ptr], 1'b0};
            r_tx_cnt     <= 4'd0;
            r_bit_no     <= 4'd0;
            r_serial_out <= 1'b0;
            r_tx_state   <= TX_SEND;
          end
        end
        TX_SEND: begin
          r_tx_cnt <= r_tx_cnt + 4'd1;
          if (r_tx_cnt == 4'd15) begin
            if (r_bit_no == 4'd9) begin
              r_serial_out <= 1'b1;
              r_tx_state   <= TX_IDLE;
            end else begin
              r_tx_shift   <= {1'b1, r_tx_shift[9:1]};
              r_serial_out <= r_tx_shift[1];
              r_bit_no     <= r_bit_no + 4'd1;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.serial_out = r_serial_out;
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
  assign bus.fifo_count = r_count;

endmodule
`default_nettype wire
